conv_sequencer: RTL and testbench
=================================

Name: conv_sequencer

Overview:
- Raster-scan controller for the convolution datapath.
- Walks every input pixel of a W x H image and issues a frame-buffer read for each one.
- Pulses pushpixel to shift each pixel into the K x K window.
- Whenever the window is valid it holds multi_act until the multiplier array returns done, then issues one output write.
- It is the frame-level sequencer above the line buffer / MAC array and replaces the free-running push/cal toggle.

Parameters:
- IMG_W, 64, image width in pixels (K <= IMG_W <= 2^ADDR_W).
- IMG_H, 64, image height in pixels (K <= IMG_H).
- K, 3, kernel size; window valid when row >= K-1 and col >= K-1.
- ADDR_W, 12, width of rd_addr / wr_addr; 2^ADDR_W >= IMG_W*IMG_H required.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin one frame; sampled only in IDLE.
- done  in  1  MAC array result ready; sampled only in CAL.
- rd_en  out  1  frame-buffer read strobe (one cycle per pixel).
- rd_addr  out  ADDR_W  linear input pixel index, row*IMG_W+col.
- pushpixel  out  1  shift current pixel into window; coincident with rd_en.
- multi_act  out  1  MAC array enable; high for every CAL cycle.
- wr_en  out  1  output-buffer write strobe.
- wr_addr  out  ADDR_W  linear output index, 0 .. (IMG_W-K+1)*(IMG_H-K+1)-1.
- busy  out  1  high whenever state != IDLE.
- fin  out  1  one-cycle pulse, frame complete.

Behaviour:
- Reset is asynchronous on rst high.
  - state=IDLE; row, col, rd_addr and wr_addr counters = 0.
  - All strobes (rd_en, pushpixel, multi_act, wr_en, fin, busy) = 0.
- Reset asserted mid-frame aborts the frame immediately and produces no fin. The next start begins a fresh frame at pixel 0.
- Outputs are decoded from registered state and counters only. There is no combinational path from start or done to any output.
- States: IDLE, PUSH, CAL, WRITE, FIN (3-bit encoding).
- IDLE:
  - All strobes low.
  - start=1 -> PUSH; counters cleared on entry.
- PUSH:
  - rd_en=1, pushpixel=1, rd_addr=row*IMG_W+col.
  - Exactly one cycle per pixel.
  - Next state:
    - window valid for (row,col) -> CAL;
    - else if last pixel (row=IMG_H-1, col=IMG_W-1) -> FIN;
    - else advance col (wrap to 0 with row+1 at IMG_W-1) -> PUSH.
- CAL:
  - multi_act=1.
  - Stay until done=1 is sampled, then -> WRITE.
  - Minimum one cycle: done already high on the first CAL cycle -> one-cycle CAL.
  - No timeout.
- WRITE:
  - wr_en=1, wr_addr = current output count, for one cycle.
  - Output count increments on exit.
  - Last pixel -> FIN; else advance row/col -> PUSH.
- FIN:
  - fin=1 for one cycle, busy still 1.
  - -> IDLE; counters cleared.
- Ignored inputs:
  - start outside IDLE is ignored (no restart, no queueing).
  - done outside CAL is ignored.
- Simultaneous events:
  - start in the same cycle as FIN has no effect.
  - start is honoured from IDLE on the following cycle at the earliest.
- Strobe exclusivity: rd_en/pushpixel, multi_act and wr_en are mutually exclusive in every cycle.
- Counters:
  - rd_addr is a linear counter that increments in step with col.
  - Neither counter wraps within a frame; both return to 0 on frame end or reset.
- Frame totals:
  - IMG_W*IMG_H pushes.
  - (IMG_W-K+1)*(IMG_H-K+1) writes.
  - Cycles = pushes + writes + sum(CAL cycles) + 1 (FIN).
- K=1: every pixel is valid and every push is followed by CAL and WRITE.

Test Plan:
- Frame timing: IMG_W=4, IMG_H=4, K=3, done tied 1, start pulsed once -> 16 PUSH with rd_addr 0..15 in order; exactly 4 writes.
  - CAL/WRITE follow pixels 10, 11, 14, 15, with wr_addr 0, 1, 2, 3.
  - fin high in the 25th cycle after the first PUSH cycle; busy low the next cycle.
- Delayed done: same config, done low for the first 3 CAL cycles and high in the 4th -> multi_act high exactly 4 cycles per output; fin 12 cycles later than the tied-done case.
- Spurious inputs:
  - start re-pulsed at pixel 5 -> ignored; rd_addr sequence unbroken.
  - done pulsed during PUSH -> no CAL entry outside valid windows.
- Reset mid-frame: rst asserted during CAL of output 2 -> all outputs 0 in the same cycle (asynchronous), no fin.
  - Subsequent start -> rd_addr restarts at 0 and wr_addr restarts at 0.
- K=1, IMG_W=3, IMG_H=2 -> 6 PUSH/CAL/WRITE triples, wr_addr 0..5.
  - Strobes never overlap (checked by assertion every cycle).
- Back-to-back frames: start held high continuously -> a second frame starts on the cycle after fin's IDLE cycle, identical address sequence.

Source files
------------

// File: rtl/conv_sequencer.sv
`timescale 1ns/1ps
// Raster-scan frame sequencer: one read/push per pixel, then a CAL/WRITE pair for each valid KxK window.
// Latency: strobes are decoded from registered state, so start/done take effect on the cycle after they are sampled.
// Backpressure: CAL holds multi_act until done is sampled; start is honoured only in IDLE.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             begin one frame (sampled only in IDLE)
//   done              MAC array result ready (sampled only in CAL)
//   rd_en/rd_addr     frame-buffer read strobe and linear pixel index row*IMG_W+col
//   pushpixel         shift current pixel into the window (coincident with rd_en)
//   multi_act         MAC array enable, high for every CAL cycle
//   wr_en/wr_addr     output-buffer write strobe and linear output index
//   busy              high whenever not idle
//   fin               one-cycle frame-complete pulse
module conv_sequencer #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int K      = 3,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              pushpixel,
    output logic              multi_act,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              fin
);

    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PUSH  = 3'd1,
        S_CAL   = 3'd2,
        S_WRITE = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     col, col_nxt;
    logic [RW-1:0]     row, row_nxt;
    logic [ADDR_W-1:0] pix, pix_nxt;
    logic [ADDR_W-1:0] outc, outc_nxt;

    logic win_vld;
    logic last_pix;

    // Window validity and end-of-frame depend only on the pixel just pushed,
    // which stays addressed through CAL and WRITE.
    assign win_vld  = (row >= ROW_FIRST) && (col >= COL_FIRST);
    assign last_pix = (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            col   <= '0;
            row   <= '0;
            pix   <= '0;
            outc  <= '0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
            pix   <= pix_nxt;
            outc  <= outc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        pix_nxt   = pix;
        outc_nxt  = outc;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_PUSH;
                    col_nxt   = '0;
                    row_nxt   = '0;
                    pix_nxt   = '0;
                    outc_nxt  = '0;
                end
            end
            S_PUSH: begin
                if (win_vld) begin
                    state_nxt = S_CAL;
                end else if (last_pix) begin
                    state_nxt = S_FIN;
                end else begin
                    state_nxt = S_PUSH;
                    col_nxt   = (col == COL_LAST) ? '0 : col + 1'b1;
                    row_nxt   = (col == COL_LAST) ? row + 1'b1 : row;
                    pix_nxt   = pix + 1'b1;
                end
            end
            S_CAL: begin
                if (done) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                outc_nxt = outc + 1'b1;
                if (last_pix) begin
                    state_nxt = S_FIN;
                end else begin
                    state_nxt = S_PUSH;
                    col_nxt   = (col == COL_LAST) ? '0 : col + 1'b1;
                    row_nxt   = (col == COL_LAST) ? row + 1'b1 : row;
                    pix_nxt   = pix + 1'b1;
                end
            end
            S_FIN: begin
                // Counters return to zero so the idle addresses read 0.
                state_nxt = S_IDLE;
                col_nxt   = '0;
                row_nxt   = '0;
                pix_nxt   = '0;
                outc_nxt  = '0;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign rd_en     = (state == S_PUSH);
    assign pushpixel = (state == S_PUSH);
    assign multi_act = (state == S_CAL);
    assign wr_en     = (state == S_WRITE);
    assign fin       = (state == S_FIN);
    assign busy      = (state != S_IDLE);
    assign rd_addr   = pix;
    assign wr_addr   = outc;

endmodule

// File: tb/tb_conv_sequencer.sv
`timescale 1ns/1ps
// Bench for conv_sequencer: two instances (4x4 K=3 and 3x2 K=1) share one
// stimulus/model path selected by sel; the model expands a frame into a queue
// of expected cycle slots and a compare process checks every cycle.
module tb_conv_sequencer;

    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic start, done;
    int   sel;

    logic          start_a, done_a, start_b, done_b;
    logic          a_rd_en, a_push, a_mact, a_wr, a_busy, a_fin;
    logic [AW-1:0] a_rd_addr, a_wr_addr;
    logic          b_rd_en, b_push, b_mact, b_wr, b_busy, b_fin;
    logic [AW-1:0] b_rd_addr, b_wr_addr;

    logic          o_rd_en, o_push, o_mact, o_wr, o_busy, o_fin;
    logic [AW-1:0] o_rd_addr, o_wr_addr;

    always_comb begin
        start_a = (sel == 0) ? start : 1'b0;
        done_a  = (sel == 0) ? done  : 1'b0;
        start_b = (sel == 1) ? start : 1'b0;
        done_b  = (sel == 1) ? done  : 1'b0;
    end

    always_comb begin
        if (sel == 0) begin
            o_rd_en = a_rd_en; o_push = a_push; o_mact = a_mact; o_wr = a_wr;
            o_busy = a_busy; o_fin = a_fin; o_rd_addr = a_rd_addr; o_wr_addr = a_wr_addr;
        end else begin
            o_rd_en = b_rd_en; o_push = b_push; o_mact = b_mact; o_wr = b_wr;
            o_busy = b_busy; o_fin = b_fin; o_rd_addr = b_rd_addr; o_wr_addr = b_wr_addr;
        end
    end

    conv_sequencer #(.IMG_W(4), .IMG_H(4), .K(3), .ADDR_W(AW)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .done(done_a),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .pushpixel(a_push), .multi_act(a_mact),
        .wr_en(a_wr), .wr_addr(a_wr_addr), .busy(a_busy), .fin(a_fin)
    );

    conv_sequencer #(.IMG_W(3), .IMG_H(2), .K(1), .ADDR_W(AW)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .done(done_b),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .pushpixel(b_push), .multi_act(b_mact),
        .wr_en(b_wr), .wr_addr(b_wr_addr), .busy(b_busy), .fin(b_fin)
    );

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int K_PUSH = 1, K_CAL = 2, K_WRITE = 3, K_FIN = 4;
    typedef struct {
        int kind;
        int addr;
    } slot_t;

    slot_t q[$];
    int    mw, mh, mk;

    // Frame expanded straight from the raster rules: push every pixel, and
    // each pixel with a complete window gets a CAL (variable length) and a WRITE.
    task automatic load_frame();
        slot_t s;
        int    o;
        o = 0;
        for (int r = 0; r < mh; r++) begin
            for (int c = 0; c < mw; c++) begin
                s.kind = K_PUSH; s.addr = r * mw + c; q.push_back(s);
                if (r >= mk - 1 && c >= mk - 1) begin
                    s.kind = K_CAL;   s.addr = 0; q.push_back(s);
                    s.kind = K_WRITE; s.addr = o; q.push_back(s);
                    o++;
                end
            end
        end
        s.kind = K_FIN; s.addr = 0; q.push_back(s);
    endtask

    // ---------------- per-cycle compare ----------------
    int cyc = 0;
    int load_cyc = 0, fin_cyc = 0, prev_fin_cyc = 0, fin_len = 0, fin_cnt = 0;
    int n_push = 0, n_cal = 0, n_wr = 0;
    int last_rd = -1;
    int wpix[$];
    int wadr[$];

    always @(negedge clk) begin
        logic [5:0] vec;
        slot_t      s;
        cyc++;
        vec = {o_rd_en, o_push, o_mact, o_wr, o_busy, o_fin};
        if (rst) begin
            q.delete();
        end else begin
            chk("strobe_excl", int'(o_rd_en) + int'(o_mact) + int'(o_wr) <= 1, 1);
            if (o_rd_en) begin n_push++; last_rd = int'(o_rd_addr); end
            if (o_mact) n_cal++;
            if (o_wr) begin n_wr++; wpix.push_back(last_rd); wadr.push_back(int'(o_wr_addr)); end
            if (o_fin) begin
                fin_cnt++; prev_fin_cyc = fin_cyc; fin_cyc = cyc; fin_len = cyc - load_cyc;
            end

            if (q.size() == 0) begin
                chk("idle_strobes", int'(vec), 0);
                chk("idle_rd_addr", int'(o_rd_addr), 0);
                chk("idle_wr_addr", int'(o_wr_addr), 0);
                if (start) begin
                    load_frame();
                    load_cyc = cyc;
                    n_push = 0; n_cal = 0; n_wr = 0;
                    wpix.delete(); wadr.delete();
                end
            end else begin
                s = q[0];
                case (s.kind)
                    K_PUSH: begin
                        chk("push_strobes", int'(vec), 6'b110010);
                        chk("rd_addr", int'(o_rd_addr), s.addr);
                        void'(q.pop_front());
                    end
                    K_CAL: begin
                        chk("cal_strobes", int'(vec), 6'b001010);
                        if (done) void'(q.pop_front());
                    end
                    K_WRITE: begin
                        chk("write_strobes", int'(vec), 6'b000110);
                        chk("wr_addr", int'(o_wr_addr), s.addr);
                        void'(q.pop_front());
                    end
                    default: begin
                        chk("fin_strobes", int'(vec), 6'b000011);
                        void'(q.pop_front());
                    end
                endcase
            end
        end
    end

    // ---------------- done driver ----------------
    int cal_need = 1;
    int done_out = 1;
    int cal_cnt  = 0;

    always @(posedge clk) begin
        #1;
        if (o_mact) cal_cnt++;
        else        cal_cnt = 0;
        done = o_mact ? (cal_cnt >= cal_need) : (done_out != 0);
    end

    // ---------------- stimulus ----------------
    task automatic set_cfg(input int s, input int need, input int dout);
        sel = s; cal_need = need; done_out = dout;
        if (s == 0) begin mw = 4; mh = 4; mk = 3; end
        else        begin mw = 3; mh = 2; mk = 1; end
    endtask

    task automatic wait_fin(input int target, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (fin_cnt >= target) begin ok = 1; break; end
        end
        #1;
        if (!ok) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic run_frame(input int spur_pix, input string name);
        int  target;
        bit  seen;
        target = fin_cnt + 1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (spur_pix >= 0) begin
            seen = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (o_rd_en && int'(o_rd_addr) == spur_pix) begin seen = 1; break; end
            end
            if (!seen) chk("spur_wait_timeout", 0, 1);
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        wait_fin(target, name);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_list(input string name, input int got[$], input int exp[$]);
        chk({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, got[i], exp[i]);
    endtask

    initial begin
        int fc;
        int exp_pix[$];
        int exp_adr[$];
        rst = 1'b1; start = 1'b0; done = 1'b0;
        set_cfg(0, 1, 1);
        #2;
        chk("reset_strobes", int'({o_rd_en, o_push, o_mact, o_wr, o_busy, o_fin}), 0);
        chk("reset_addrs", int'(o_rd_addr) + int'(o_wr_addr), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Tied done: 16 pushes + 4 CAL + 4 WRITE + FIN -> fin 25 cycles in.
        set_cfg(0, 1, 1);
        run_frame(-1, "tied");
        chk("tied_fin_len", fin_len, 25);
        chk("tied_pushes", n_push, 16);
        chk("tied_cal", n_cal, 4);
        chk("tied_writes", n_wr, 4);
        exp_pix = '{10, 11, 14, 15};
        exp_adr = '{0, 1, 2, 3};
        chk_list("tied_wpix", wpix, exp_pix);
        chk_list("tied_wadr", wadr, exp_adr);

        // Done arrives on the 4th CAL cycle: 12 extra cycles.
        set_cfg(0, 4, 0);
        run_frame(-1, "delay");
        chk("delay_fin_len", fin_len, 37);
        chk("delay_cal", n_cal, 16);
        chk("delay_writes", n_wr, 4);

        // Spurious start at pixel 5, done high outside CAL, 2-cycle CAL.
        set_cfg(0, 2, 1);
        run_frame(5, "spur");
        chk("spur_fin_len", fin_len, 29);
        chk("spur_pushes", n_push, 16);
        chk("spur_cal", n_cal, 8);
        chk_list("spur_wpix", wpix, exp_pix);

        // Reset during CAL of output 2.
        set_cfg(0, 4, 0);
        fc = fin_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (o_mact && int'(o_wr_addr) == 2) begin seen = 1; break; end
            end
            if (!seen) chk("rst_wait_timeout", 0, 1);
        end
        #2 rst = 1'b1;
        #1;
        chk("midrst_strobes", int'({o_rd_en, o_push, o_mact, o_wr, o_busy, o_fin}), 0);
        chk("midrst_rd_addr", int'(o_rd_addr), 0);
        chk("midrst_wr_addr", int'(o_wr_addr), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_fin", fin_cnt, fc);
        set_cfg(0, 1, 1);
        run_frame(-1, "after_rst");
        chk("after_rst_fin_len", fin_len, 25);
        chk_list("after_rst_wadr", wadr, exp_adr);

        // K=1 on a 3x2 image: every pixel gets CAL and WRITE.
        set_cfg(1, 1, 1);
        run_frame(-1, "k1");
        chk("k1_fin_len", fin_len, 19);
        chk("k1_pushes", n_push, 6);
        chk("k1_cal", n_cal, 6);
        exp_adr = '{0, 1, 2, 3, 4, 5};
        chk_list("k1_wadr", wadr, exp_adr);
        chk_list("k1_wpix", wpix, exp_adr);

        // Start held high: second frame begins right after the post-fin idle cycle.
        set_cfg(0, 1, 1);
        fc = fin_cnt;
        @(posedge clk); #1 start = 1'b1;
        wait_fin(fc + 2, "b2b");
        start = 1'b0;
        chk("b2b_fin_len", fin_len, 25);
        chk("b2b_gap", load_cyc - prev_fin_cyc, 1);
        chk("b2b_writes", n_wr, 4);
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_no_third", fin_cnt, fc + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
